keypad_pin_lock: RTL and testbench

//  Consumes the keypad scanner's ASCII code (digito) and key_detected strobe; turns each physical press into one event.

---
 rtl/keypad_pin_lock_pkg.sv | 25 ++
 rtl/key_press_filter.sv | 41 ++++
 rtl/keypad_pin_lock.sv | 129 ++++++++++++
 tb/tb_keypad_pin_lock.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pin_lock_pkg.sv
// Shared key codes, FSM state encoding and key classification helpers for the keypad PIN lock.
package keypad_pin_lock_pkg;

    localparam logic [7:0] KEY_STAR = 8'h2A;
    localparam logic [7:0] KEY_HASH = 8'h23;
    localparam logic [7:0] KEY_0    = 8'h30;
    localparam logic [7:0] KEY_9    = 8'h39;

    typedef enum logic [1:0] {
        StEntry   = 2'd0,
        StCheck   = 2'd1,
        StOpen    = 2'd2,
        StLockout = 2'd3
    } state_t;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= KEY_0) && (c <= KEY_9);
    endfunction

    // Digits are masked on the display; every other key is echoed verbatim.
    function automatic logic [7:0] echo_of(input logic [7:0] c);
        return is_digit(c) ? KEY_STAR : c;
    endfunction

endpackage

// File: rtl/key_press_filter.sv
// Turns the scanner's repeating key_detected strobe into one registered accept per physical press.
module key_press_filter #(
    parameter int unsigned CICLOS_RELEASE = 1500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_detected,
    input  logic [7:0] digito,
    output logic       accept,
    output logic [7:0] code
);

    localparam int unsigned RW = (CICLOS_RELEASE > 1) ? $clog2(CICLOS_RELEASE) : 1;

    logic          armed_q;
    logic [RW-1:0] rel_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed_q   <= 1'b1;
            rel_cnt_q <= '0;
            accept    <= 1'b0;
            code      <= 8'h00;
        end else begin
            accept <= key_detected & armed_q;
            code   <= digito;
            if (key_detected) begin
                armed_q   <= 1'b0;
                rel_cnt_q <= '0;
            end else if (!armed_q) begin
                // Re-arm only after a full release window of consecutive idle cycles.
                if (rel_cnt_q == RW'(CICLOS_RELEASE - 1)) begin
                    armed_q <= 1'b1;
                end else begin
                    rel_cnt_q <= rel_cnt_q + RW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/keypad_pin_lock.sv
// Keypad PIN lock: code entry buffer, submission check, unlock hold and wrong-attempt lockout.
module keypad_pin_lock
    import keypad_pin_lock_pkg::*;
#(
    parameter int unsigned PIN_LEN        = 4,
    parameter logic [63:0] PIN_CODE       = 64'h3132_3334,
    parameter int unsigned MAX_TRIES      = 3,
    parameter int unsigned CICLOS_RELEASE = 1500000,
    parameter int unsigned CICLOS_OPEN    = 250000000,
    parameter int unsigned CICLOS_LOCKOUT = 500000000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [7:0]                     digito,
    input  logic                           key_detected,
    output logic                           key_valid,
    output logic [7:0]                     key_echo,
    output logic [$clog2(PIN_LEN+1)-1:0]   digit_count,
    output logic [$clog2(MAX_TRIES+1)-1:0] tries_left,
    output logic                           unlocked,
    output logic                           error_pulse,
    output logic                           locked_out
);

    localparam int unsigned CW   = $clog2(PIN_LEN + 1);
    localparam int unsigned TRW  = $clog2(MAX_TRIES + 1);
    localparam int unsigned BW   = 8 * PIN_LEN;
    localparam int unsigned TMAX = (CICLOS_OPEN > CICLOS_LOCKOUT) ? CICLOS_OPEN : CICLOS_LOCKOUT;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    logic          accept;
    logic [7:0]    code;
    state_t        state_q;
    logic [BW-1:0] buf_q;
    logic [TW-1:0] timer_q;

    key_press_filter #(
        .CICLOS_RELEASE(CICLOS_RELEASE)
    ) u_filter (
        .clk          (clk),
        .rst          (rst),
        .key_detected (key_detected),
        .digito       (digito),
        .accept       (accept),
        .code         (code)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StEntry;
            buf_q       <= '0;
            timer_q     <= '0;
            key_valid   <= 1'b0;
            key_echo    <= 8'h00;
            digit_count <= '0;
            tries_left  <= TRW'(MAX_TRIES);
            unlocked    <= 1'b0;
            error_pulse <= 1'b0;
            locked_out  <= 1'b0;
        end else begin
            key_valid   <= 1'b0;
            error_pulse <= 1'b0;
            case (state_q)
                StEntry: begin
                    if (accept) begin
                        key_valid <= 1'b1;
                        key_echo  <= echo_of(code);
                        if (is_digit(code)) begin
                            // A full buffer silently drops further digits.
                            if (digit_count < CW'(PIN_LEN)) begin
                                buf_q       <= (buf_q << 8) | BW'(code);
                                digit_count <= digit_count + CW'(1);
                            end
                        end else if (code == KEY_STAR) begin
                            buf_q       <= '0;
                            digit_count <= '0;
                        end else if (code == KEY_HASH) begin
                            state_q <= StCheck;
                        end
                    end
                end
                StCheck: begin
                    buf_q       <= '0;
                    digit_count <= '0;
                    if ((digit_count == CW'(PIN_LEN)) && (buf_q == PIN_CODE[BW-1:0])) begin
                        state_q    <= StOpen;
                        unlocked   <= 1'b1;
                        tries_left <= TRW'(MAX_TRIES);
                        timer_q    <= TW'(CICLOS_OPEN - 1);
                    end else begin
                        error_pulse <= 1'b1;
                        tries_left  <= tries_left - TRW'(1);
                        if (tries_left == TRW'(1)) begin
                            state_q    <= StLockout;
                            locked_out <= 1'b1;
                            timer_q    <= TW'(CICLOS_LOCKOUT - 1);
                        end else begin
                            state_q <= StEntry;
                        end
                    end
                end
                StOpen: begin
                    // Expiry is tested first so it wins over a same-cycle '*'.
                    if (timer_q == '0) begin
                        state_q  <= StEntry;
                        unlocked <= 1'b0;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                        if (accept && (code == KEY_STAR)) begin
                            state_q  <= StEntry;
                            unlocked <= 1'b0;
                        end
                    end
                end
                StLockout: begin
                    if (timer_q == '0) begin
                        state_q    <= StEntry;
                        locked_out <= 1'b0;
                        tries_left <= TRW'(MAX_TRIES);
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                default: state_q <= StEntry;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_pin_lock.sv
// Directed self-checking bench for keypad_pin_lock with shortened release/open/lockout windows.
module tb_keypad_pin_lock;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_detected = 1'b0;
    logic [7:0] digito = 8'h00;
    logic       key_valid;
    logic [7:0] key_echo;
    logic [2:0] digit_count;
    logic [1:0] tries_left;
    logic       unlocked;
    logic       error_pulse;
    logic       locked_out;

    int checks = 0;
    int failures = 0;
    int n;
    int seen;
    logic [7:0] last_echo;

    always #5 clk = ~clk;

    keypad_pin_lock #(
        .PIN_LEN        (4),
        .PIN_CODE       (64'h3132_3334),
        .MAX_TRIES      (3),
        .CICLOS_RELEASE (4),
        .CICLOS_OPEN    (20),
        .CICLOS_LOCKOUT (50)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .digito       (digito),
        .key_detected (key_detected),
        .key_valid    (key_valid),
        .key_echo     (key_echo),
        .digit_count  (digit_count),
        .tries_left   (tries_left),
        .unlocked     (unlocked),
        .error_pulse  (error_pulse),
        .locked_out   (locked_out)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_key_valid"}, key_valid, 1'b0);
        chk({tag, "_key_echo"}, key_echo, 8'h00);
        chk({tag, "_digit_count"}, digit_count, 3'd0);
        chk({tag, "_tries_left"}, tries_left, 2'd3);
        chk({tag, "_unlocked"}, unlocked, 1'b0);
        chk({tag, "_error_pulse"}, error_pulse, 1'b0);
        chk({tag, "_locked_out"}, locked_out, 1'b0);
    endtask

    // One press: accept at the first edge, key_valid after the second, re-armed after the fifth.
    task automatic press(input logic [7:0] c, input logic exp_valid, input logic [7:0] exp_echo,
                         input string tag);
        digito = c;
        key_detected = 1'b1;
        tick();
        key_detected = 1'b0;
        tick();
        chk({tag, "_valid"}, key_valid, exp_valid);
        if (exp_valid) chk({tag, "_echo"}, key_echo, exp_echo);
        tick();
        tick();
        tick();
    endtask

    // Press '#' and return right after the edge where the check result becomes visible.
    task automatic submit(input string tag);
        digito = 8'h23;
        key_detected = 1'b1;
        tick();
        key_detected = 1'b0;
        tick();
        chk({tag, "_hash_valid"}, key_valid, 1'b1);
        chk({tag, "_hash_echo"}, key_echo, 8'h23);
        tick();
    endtask

    task automatic enter_1234(input string tag);
        press(8'h31, 1'b1, 8'h2A, {tag, "_d1"});
        press(8'h32, 1'b1, 8'h2A, {tag, "_d2"});
        press(8'h33, 1'b1, 8'h2A, {tag, "_d3"});
        press(8'h34, 1'b1, 8'h2A, {tag, "_d4"});
    endtask

    initial begin
        // Power-on reset
        tick();
        tick();
        chk_reset_outputs("por");
        rst = 1'b1;
        tick();

        // Held key produces exactly one event
        digito = 8'h35;
        key_detected = 1'b1;
        n = 0;
        last_echo = 8'h00;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (key_valid) begin
                n++;
                last_echo = key_echo;
            end
        end
        key_detected = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (key_valid) begin
                n++;
                last_echo = key_echo;
            end
        end
        chk("hold_pulses", n, 1);
        chk("hold_echo", last_echo, 8'h2A);
        chk("hold_count", digit_count, 3'd1);
        press(8'h35, 1'b1, 8'h2A, "second_press");
        chk("second_count", digit_count, 3'd2);
        press(8'h41, 1'b1, 8'h41, "ignored_A");
        chk("ignored_count", digit_count, 3'd2);
        press(8'h2A, 1'b1, 8'h2A, "star");
        chk("star_count", digit_count, 3'd0);

        // Wrong code
        press(8'h31, 1'b1, 8'h2A, "w_d1");
        press(8'h32, 1'b1, 8'h2A, "w_d2");
        press(8'h33, 1'b1, 8'h2A, "w_d3");
        press(8'h35, 1'b1, 8'h2A, "w_d4");
        chk("wrong_count_full", digit_count, 3'd4);
        submit("wrong");
        chk("wrong_error", error_pulse, 1'b1);
        chk("wrong_tries", tries_left, 2'd2);
        chk("wrong_count", digit_count, 3'd0);
        chk("wrong_unlocked", unlocked, 1'b0);
        chk("wrong_locked", locked_out, 1'b0);
        tick();
        chk("wrong_error_1cyc", error_pulse, 1'b0);
        tick();

        // Asynchronous reset mid-stream
        press(8'h31, 1'b1, 8'h2A, "pre_rst_d1");
        press(8'h32, 1'b1, 8'h2A, "pre_rst_d2");
        chk("pre_rst_count", digit_count, 3'd2);
        rst = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        tick();
        rst = 1'b1;
        tick();

        // Correct code with latency and hold time
        enter_1234("ok");
        digito = 8'h23;
        key_detected = 1'b1;
        tick();
        key_detected = 1'b0;
        tick();
        chk("ok_unlock_early", unlocked, 1'b0);
        tick();
        chk("ok_unlock", unlocked, 1'b1);
        chk("ok_tries", tries_left, 2'd3);
        n = 1;
        for (int i = 0; i < 40 && unlocked; i++) begin
            tick();
            if (unlocked) n++;
        end
        chk("ok_hold_cycles", n, 20);
        chk("ok_relocked", unlocked, 1'b0);

        // Overflow digit dropped, keys in OPEN, '*' relock
        enter_1234("ovf");
        press(8'h39, 1'b1, 8'h2A, "ovf_d5");
        chk("ovf_count", digit_count, 3'd4);
        submit("ovf");
        chk("ovf_unlock", unlocked, 1'b1);
        tick();
        tick();
        press(8'h37, 1'b0, 8'h00, "open_digit");
        chk("open_digit_unlocked", unlocked, 1'b1);
        press(8'h2A, 1'b0, 8'h00, "open_star");
        chk("open_star_relock", unlocked, 1'b0);
        chk("open_star_count", digit_count, 3'd0);

        // Clear then correct code
        press(8'h31, 1'b1, 8'h2A, "clr_d1");
        press(8'h32, 1'b1, 8'h2A, "clr_d2");
        press(8'h2A, 1'b1, 8'h2A, "clr_star");
        chk("clr_count", digit_count, 3'd0);
        enter_1234("clr");
        submit("clr");
        chk("clr_unlock", unlocked, 1'b1);
        for (int i = 0; i < 40 && unlocked; i++) tick();
        chk("clr_expired", unlocked, 1'b0);

        // Lockout: empty, short and wrong submissions
        submit("empty");
        chk("empty_error", error_pulse, 1'b1);
        chk("empty_tries", tries_left, 2'd2);
        tick();
        tick();
        press(8'h31, 1'b1, 8'h2A, "short_d1");
        submit("short");
        chk("short_error", error_pulse, 1'b1);
        chk("short_tries", tries_left, 2'd1);
        chk("short_locked", locked_out, 1'b0);
        tick();
        tick();
        for (int i = 0; i < 4; i++) press(8'h39, 1'b1, 8'h2A, "lock_d");
        submit("lock");
        chk("lock_error", error_pulse, 1'b1);
        chk("lock_tries", tries_left, 2'd0);
        chk("lock_locked", locked_out, 1'b1);
        n = 1;
        seen = 0;
        for (int i = 0; i < 80 && locked_out; i++) begin
            if (i == 5) begin
                digito = 8'h31;
                key_detected = 1'b1;
            end
            if (i == 6) key_detected = 1'b0;
            tick();
            if (key_valid) seen++;
            if (locked_out) n++;
        end
        chk("lock_cycles", n, 50);
        chk("lock_no_key_valid", seen, 0);
        chk("lock_released", locked_out, 1'b0);
        chk("lock_tries_restored", tries_left, 2'd3);

        // Usable again after lockout
        enter_1234("post");
        submit("post");
        chk("post_unlock", unlocked, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
